// File: rtl/e203_exu_wbck_arb_n_if.sv
// Writeback arbiter bus: per-channel result requests in, integer/FP regfile writes out.
interface e203_exu_wbck_arb_n_if #(
    parameter int unsigned NCH     = 4,
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RFIDX_W = 5,
    parameter int unsigned FLAG_W  = 5
);
    logic [NCH-1:0]         wbck_i_valid;
    logic [NCH-1:0]         wbck_i_ready;
    logic [NCH*XLEN-1:0]    wbck_i_wdat;
    logic [NCH*RFIDX_W-1:0] wbck_i_rdidx;
    logic [NCH-1:0]         wbck_i_rdfpu;
    logic [NCH*FLAG_W-1:0]  wbck_i_flags;
    logic                   wbck_stall;
    logic                   fflags_clr;
    logic                   rf_wbck_o_ena;
    logic [XLEN-1:0]        rf_wbck_o_wdat;
    logic [RFIDX_W-1:0]     rf_wbck_o_rdidx;
    logic                   fp_wbck_o_ena;
    logic [XLEN-1:0]        fp_wbck_o_wdat;
    logic [RFIDX_W-1:0]     fp_wbck_o_rdidx;
    logic [FLAG_W-1:0]      fflags_o;

    modport master (
        output wbck_i_valid, wbck_i_wdat, wbck_i_rdidx, wbck_i_rdfpu, wbck_i_flags,
               wbck_stall, fflags_clr,
        input  wbck_i_ready, rf_wbck_o_ena, rf_wbck_o_wdat, rf_wbck_o_rdidx,
               fp_wbck_o_ena, fp_wbck_o_wdat, fp_wbck_o_rdidx, fflags_o
    );

    modport slave (
        input  wbck_i_valid, wbck_i_wdat, wbck_i_rdidx, wbck_i_rdfpu, wbck_i_flags,
               wbck_stall, fflags_clr,
        output wbck_i_ready, rf_wbck_o_ena, rf_wbck_o_wdat, rf_wbck_o_rdidx,
               fp_wbck_o_ena, fp_wbck_o_wdat, fp_wbck_o_rdidx, fflags_o
    );
endinterface

// File: rtl/e203_exu_wbck_arb_n.sv
// N-channel EXU writeback arbiter: fixed or round-robin grant, registered
// integer/FP regfile write stage and sticky FP exception flags.
module e203_exu_wbck_arb_n #(
    parameter int unsigned NCH     = 4,
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RFIDX_W = 5,
    parameter int unsigned FLAG_W  = 5,
    parameter int unsigned RR_MODE = 1
) (
    input logic                 clk,
    input logic                 rst,
    e203_exu_wbck_arb_n_if.slave bus
);
    localparam int unsigned PTR_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [PTR_W:0]   NCH_L  = (PTR_W+1)'(NCH);
    localparam logic [PTR_W-1:0] LAST_L = PTR_W'(NCH - 1);

    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   gidx_c;
    logic [PTR_W:0]     scan_c;
    logic [NCH-1:0]     grant_c;
    logic               hs_c;
    logic [XLEN-1:0]    sel_wdat_c;
    logic [RFIDX_W-1:0] sel_rdidx_c;
    logic               sel_rdfpu_c;
    logic [FLAG_W-1:0]  sel_flags_c;

    logic               rf_ena;
    logic [XLEN-1:0]    rf_wdat;
    logic [RFIDX_W-1:0] rf_rdidx;
    logic               fp_ena;
    logic [XLEN-1:0]    fp_wdat;
    logic [RFIDX_W-1:0] fp_rdidx;
    logic [FLAG_W-1:0]  fflags;

    // Scan channels starting at ptr (RR) or 0 (fixed), wrapping at NCH.
    always_comb begin
        grant_c = '0;
        gidx_c  = '0;
        hs_c    = 1'b0;
        scan_c  = '0;
        if (!bus.wbck_stall) begin
            for (int k = 0; k < int'(NCH); k++) begin
                scan_c = (RR_MODE != 0) ? ({1'b0, ptr} + (PTR_W+1)'(k)) : (PTR_W+1)'(k);
                if (scan_c >= NCH_L) scan_c = scan_c - NCH_L;
                if (!hs_c && bus.wbck_i_valid[scan_c[PTR_W-1:0]]) begin
                    hs_c   = 1'b1;
                    gidx_c = scan_c[PTR_W-1:0];
                end
            end
            if (hs_c) grant_c[gidx_c] = 1'b1;
        end
    end

    assign bus.wbck_i_ready = grant_c;

    assign sel_wdat_c  = bus.wbck_i_wdat[32'(gidx_c)*XLEN +: XLEN];
    assign sel_rdidx_c = bus.wbck_i_rdidx[32'(gidx_c)*RFIDX_W +: RFIDX_W];
    assign sel_flags_c = bus.wbck_i_flags[32'(gidx_c)*FLAG_W +: FLAG_W];
    assign sel_rdfpu_c = bus.wbck_i_rdfpu[gidx_c];

    // Round-robin pointer moves just past the last granted channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (hs_c) begin
            ptr <= (gidx_c == LAST_L) ? '0 : gidx_c + PTR_W'(1);
        end
    end

    // Write stage: one-cycle enable pulse per handshake; x0 writes are swallowed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_ena   <= 1'b0;
            rf_wdat  <= '0;
            rf_rdidx <= '0;
            fp_ena   <= 1'b0;
            fp_wdat  <= '0;
            fp_rdidx <= '0;
        end else begin
            rf_ena <= hs_c && !sel_rdfpu_c && (sel_rdidx_c != '0);
            fp_ena <= hs_c && sel_rdfpu_c;
            if (hs_c && !sel_rdfpu_c) begin
                rf_wdat  <= sel_wdat_c;
                rf_rdidx <= sel_rdidx_c;
            end
            if (hs_c && sel_rdfpu_c) begin
                fp_wdat  <= sel_wdat_c;
                fp_rdidx <= sel_rdidx_c;
            end
        end
    end

    // Sticky flags: a concurrent clear wipes history but keeps the incoming flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fflags <= '0;
        end else if (hs_c && sel_rdfpu_c) begin
            fflags <= (bus.fflags_clr ? '0 : fflags) | sel_flags_c;
        end else if (bus.fflags_clr) begin
            fflags <= '0;
        end
    end

    assign bus.rf_wbck_o_ena   = rf_ena;
    assign bus.rf_wbck_o_wdat  = rf_wdat;
    assign bus.rf_wbck_o_rdidx = rf_rdidx;
    assign bus.fp_wbck_o_ena   = fp_ena;
    assign bus.fp_wbck_o_wdat  = fp_wdat;
    assign bus.fp_wbck_o_rdidx = fp_rdidx;
    assign bus.fflags_o        = fflags;
endmodule

// File: tb/tb_e203_exu_wbck_arb_n.sv
// Scoreboard bench for the writeback arbiter: a round-robin and a fixed-priority instance.
module tb_e203_exu_wbck_arb_n;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   cyc;

    typedef struct {
        int          due;
        bit          fp;
        logic [31:0] wdat;
        logic [4:0]  idx;
    } wr_t;

    wr_t         q_r[$];
    wr_t         q_f[$];
    logic [31:0] ch_wdat[4];
    logic [4:0]  ch_idx[4];
    bit          ch_fp[4];
    logic [4:0]  ch_fl[4];

    e203_exu_wbck_arb_n_if #(.NCH(4), .XLEN(32), .RFIDX_W(5), .FLAG_W(5)) bus_r ();
    e203_exu_wbck_arb_n_if #(.NCH(4), .XLEN(32), .RFIDX_W(5), .FLAG_W(5)) bus_f ();

    e203_exu_wbck_arb_n #(.NCH(4), .XLEN(32), .RFIDX_W(5), .FLAG_W(5), .RR_MODE(1)) dut_r (
        .clk(clk), .rst(rst), .bus(bus_r)
    );
    e203_exu_wbck_arb_n #(.NCH(4), .XLEN(32), .RFIDX_W(5), .FLAG_W(5), .RR_MODE(0)) dut_f (
        .clk(clk), .rst(rst), .bus(bus_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Pops the expected write due this cycle and compares it with what the DUT drives.
    function automatic void mon(input bit rr, input logic rfe, input logic [31:0] rfd,
                                input logic [4:0] rfi, input logic fpe,
                                input logic [31:0] fpd, input logic [4:0] fpi);
        wr_t e;
        bit  have;
        have = 1'b0;
        if (rr && q_r.size() > 0 && q_r[0].due <= cyc) begin
            e = q_r.pop_front();
            have = 1'b1;
        end else if (!rr && q_f.size() > 0 && q_f[0].due <= cyc) begin
            e = q_f.pop_front();
            have = 1'b1;
        end
        if (have) begin
            cmp(rr ? "rr_wr_kind" : "fx_wr_kind", {30'd0, rfe, fpe}, e.fp ? 32'd1 : 32'd2);
            cmp(rr ? "rr_wr_data" : "fx_wr_data", e.fp ? fpd : rfd, e.wdat);
            cmp(rr ? "rr_wr_idx" : "fx_wr_idx", {27'd0, e.fp ? fpi : rfi}, {27'd0, e.idx});
        end else if (rfe || fpe) begin
            checks++;
            errors++;
            $display("FAIL %s: got rf_ena=%0b fp_ena=%0b expected no write (cycle %0d)",
                     rr ? "rr_unexpected_write" : "fx_unexpected_write", rfe, fpe, cyc);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            mon(1'b1, bus_r.rf_wbck_o_ena, bus_r.rf_wbck_o_wdat, bus_r.rf_wbck_o_rdidx,
                bus_r.fp_wbck_o_ena, bus_r.fp_wbck_o_wdat, bus_r.fp_wbck_o_rdidx);
            mon(1'b0, bus_f.rf_wbck_o_ena, bus_f.rf_wbck_o_wdat, bus_f.rf_wbck_o_rdidx,
                bus_f.fp_wbck_o_ena, bus_f.fp_wbck_o_wdat, bus_f.fp_wbck_o_rdidx);
        end
    end

    task automatic set_ch(input int ch, input logic [31:0] d, input logic [4:0] idx,
                          input bit fp, input logic [4:0] fl);
        ch_wdat[ch] = d;
        ch_idx[ch]  = idx;
        ch_fp[ch]   = fp;
        ch_fl[ch]   = fl;
        bus_r.wbck_i_wdat[ch*32 +: 32] = d;
        bus_r.wbck_i_rdidx[ch*5 +: 5]  = idx;
        bus_r.wbck_i_rdfpu[ch]         = fp;
        bus_r.wbck_i_flags[ch*5 +: 5]  = fl;
        bus_f.wbck_i_wdat[ch*32 +: 32] = d;
        bus_f.wbck_i_rdidx[ch*5 +: 5]  = idx;
        bus_f.wbck_i_rdfpu[ch]         = fp;
        bus_f.wbck_i_flags[ch*5 +: 5]  = fl;
    endtask

    // One cycle: drive valid, check ready mid-cycle, queue the write expected next cycle.
    task automatic step(input bit rr, input logic [3:0] v, input logic [3:0] exp, input string nm);
        int  g;
        wr_t e;
        if (rr) bus_r.wbck_i_valid = v;
        else    bus_f.wbck_i_valid = v;
        @(negedge clk);
        cmp(nm, {28'd0, rr ? bus_r.wbck_i_ready : bus_f.wbck_i_ready}, {28'd0, exp});
        g = -1;
        for (int i = 0; i < 4; i++) if (exp[i]) g = i;
        if (g >= 0 && !(ch_fp[g] == 1'b0 && ch_idx[g] == 5'd0)) begin
            e.due  = cyc + 1;
            e.fp   = ch_fp[g];
            e.wdat = ch_wdat[g];
            e.idx  = ch_idx[g];
            if (rr) q_r.push_back(e);
            else    q_f.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        rst    = 1'b1;
        bus_r.wbck_i_valid = '0; bus_r.wbck_stall = 1'b0; bus_r.fflags_clr = 1'b0;
        bus_f.wbck_i_valid = '0; bus_f.wbck_stall = 1'b0; bus_f.fflags_clr = 1'b0;
        for (int i = 0; i < 4; i++) set_ch(i, 32'h1111_1111 * 32'(i + 1), 5'(i + 1), 1'b0, 5'd0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        cmp("reset_rf_ena", {31'd0, bus_r.rf_wbck_o_ena}, 32'd0);
        cmp("reset_fp_ena", {31'd0, bus_r.fp_wbck_o_ena}, 32'd0);
        cmp("reset_fflags", {27'd0, bus_r.fflags_o}, 32'd0);
        cmp("reset_rf_wdat", bus_r.rf_wbck_o_wdat, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Fixed priority: ch1 always beats ch3.
        step(1'b0, 4'b1010, 4'b0010, "fx_ch1_over_ch3_a");
        step(1'b0, 4'b1010, 4'b0010, "fx_ch1_over_ch3_b");
        step(1'b0, 4'b1010, 4'b0010, "fx_ch1_over_ch3_c");
        step(1'b0, 4'b1000, 4'b1000, "fx_ch3_alone");
        step(1'b0, 4'b1111, 4'b0001, "fx_all_valid");
        step(1'b0, 4'b0000, 4'b0000, "fx_idle");

        // Round-robin rotation with all channels requesting.
        step(1'b1, 4'b1111, 4'b0001, "rr_rot_0");
        step(1'b1, 4'b1111, 4'b0010, "rr_rot_1");
        step(1'b1, 4'b1111, 4'b0100, "rr_rot_2");
        step(1'b1, 4'b1111, 4'b1000, "rr_rot_3");

        // x0 integer write: accepted, no enable, pointer still advances.
        set_ch(2, 32'hDEAD_BEEF, 5'd0, 1'b0, 5'd0);
        step(1'b1, 4'b0100, 4'b0100, "rr_x0_ready");
        step(1'b1, 4'b1111, 4'b1000, "rr_after_x0");
        set_ch(2, 32'h3333_3333, 5'd3, 1'b0, 5'd0);

        // Stall blocks grants and freezes the pointer.
        step(1'b1, 4'b0010, 4'b0010, "rr_ch1_only");
        bus_r.wbck_stall = 1'b1;
        step(1'b1, 4'b1111, 4'b0000, "rr_stall_a");
        step(1'b1, 4'b1111, 4'b0000, "rr_stall_b");
        bus_r.wbck_stall = 1'b0;
        step(1'b1, 4'b1111, 4'b0100, "rr_stall_release");

        // Sticky FP flags, clear-with-new-flags, and int-channel flags ignored.
        set_ch(0, 32'h3F80_0000, 5'd7, 1'b1, 5'b00011);
        step(1'b1, 4'b0001, 4'b0001, "rr_fp_a");
        cmp("fflags_first", {27'd0, bus_r.fflags_o}, 32'h03);
        set_ch(0, 32'h4000_0000, 5'd8, 1'b1, 5'b10000);
        step(1'b1, 4'b0001, 4'b0001, "rr_fp_b");
        step(1'b1, 4'b0000, 4'b0000, "rr_idle_a");
        cmp("fflags_accum", {27'd0, bus_r.fflags_o}, 32'h13);
        set_ch(0, 32'h4040_0000, 5'd9, 1'b1, 5'b00100);
        bus_r.fflags_clr = 1'b1;
        step(1'b1, 4'b0001, 4'b0001, "rr_fp_clr");
        bus_r.fflags_clr = 1'b0;
        cmp("fflags_clr_and_new", {27'd0, bus_r.fflags_o}, 32'h04);
        set_ch(1, 32'h5555_5555, 5'd10, 1'b0, 5'b11111);
        step(1'b1, 4'b0010, 4'b0010, "rr_int_flags");
        cmp("fflags_int_ignored", {27'd0, bus_r.fflags_o}, 32'h04);
        bus_r.fflags_clr = 1'b1;
        step(1'b1, 4'b0000, 4'b0000, "rr_idle_clr");
        bus_r.fflags_clr = 1'b0;
        cmp("fflags_cleared", {27'd0, bus_r.fflags_o}, 32'h00);

        // Reset with a write in the output register.
        set_ch(0, 32'h4080_0000, 5'd11, 1'b1, 5'b01000);
        step(1'b1, 4'b0001, 4'b0001, "rr_fp_pre_rst");
        bus_r.wbck_i_valid = 4'b0100;
        @(negedge clk);
        cmp("rr_pre_rst_ready", {28'd0, bus_r.wbck_i_ready}, 32'h4);
        @(posedge clk);
        #1;
        bus_r.wbck_i_valid = 4'b0000;
        cmp("pending_rf_ena", {31'd0, bus_r.rf_wbck_o_ena}, 32'd1);
        cmp("pending_fflags", {27'd0, bus_r.fflags_o}, 32'h08);
        rst = 1'b1;
        #1;
        cmp("mid_rst_rf_ena", {31'd0, bus_r.rf_wbck_o_ena}, 32'd0);
        cmp("mid_rst_fp_ena", {31'd0, bus_r.fp_wbck_o_ena}, 32'd0);
        cmp("mid_rst_fflags", {27'd0, bus_r.fflags_o}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b1, 4'b1111, 4'b0001, "rr_after_rst");
        step(1'b1, 4'b0000, 4'b0000, "rr_final_idle");
        step(1'b1, 4'b0000, 4'b0000, "rr_drain");

        cmp("scoreboard_empty", 32'(q_r.size() + q_f.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
